// File: rtl/ias_mem_pkg.sv
// Purpose: shared word/byte constants, controller state encoding and byte lane helpers.
// Latency: none (definitions only).
// Backpressure: not applicable.
package ias_mem_pkg;

    localparam int WORD_W     = 40;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 5;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        WR_VERIFY,
        RD_ADDR,
        RD_CAP,
        DONE
    } ctrl_state_t;

    // Byte k of a word sits at bits [8k+7:8k].
    function automatic logic [BYTE_W-1:0] get_byte(input logic [WORD_W-1:0] w,
                                                   input logic [2:0]        k);
        logic [5:0] sh;
        sh = {k, 3'b000};
        return BYTE_W'(w >> sh);
    endfunction

    function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] w,
                                                   input logic [2:0]        k,
                                                   input logic [BYTE_W-1:0] b);
        logic [5:0] sh;
        sh = {k, 3'b000};
        return (w & ~(WORD_W'(8'hFF) << sh)) | (WORD_W'(b) << sh);
    endfunction

endpackage

// File: rtl/ias_mem_ctrl_if.sv
// Purpose: request/response and byte-array bus bundle for the IAS word memory controller.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready on requests; responses and array accesses have none.
// Ports: req_* (word request), rsp_* (response pulse + data/error), mem_* (byte array side).
// slave = controller view, master = CPU/array environment view.
interface ias_mem_ctrl_if #(
    parameter int ADDR_W      = 12,
    parameter int BYTE_ADDR_W = 15
);
    import ias_mem_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [ADDR_W-1:0]      req_addr;
    logic [WORD_W-1:0]      req_wdata;
    logic                   rsp_valid;
    logic [WORD_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic [BYTE_ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0]      mem_wdata;
    logic                   mem_set;
    logic [BYTE_W-1:0]      mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_set
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_set
    );

endinterface

// File: rtl/ias_byte_addr_gen.sv
// Purpose: byte address of byte k of a word: 5*addr + k, widened before the arithmetic.
// Latency: combinational.
// Backpressure: none.
// Ports: addr (word address), k (byte index 0..4), byte_addr (array byte address).
module ias_byte_addr_gen #(
    parameter int ADDR_W      = 12,
    parameter int BYTE_ADDR_W = 15
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic [2:0]             k,
    output logic [BYTE_ADDR_W-1:0] byte_addr
);

    logic [BYTE_ADDR_W-1:0] addr_ext;

    // Widen first so 4*addr does not lose its top bits at ADDR_W.
    assign addr_ext  = BYTE_ADDR_W'(addr);
    assign byte_addr = (addr_ext << 2) + addr_ext + BYTE_ADDR_W'(k);

endmodule

// File: rtl/ias_mem_ctrl.sv
// Purpose: serialise 40-bit word read/write requests into five byte accesses on a latch array.
// Latency: write 16 cycles (21 with IAS_MEMCTRL_READBACK_EN), read 11, out-of-range 1, accept to rsp_valid.
// Backpressure: req_ready only in IDLE, one request in flight; rsp_valid cannot be stalled.
// Ports: clk, rst (sync, active-high), bus (ias_mem_ctrl_if.slave: req_*, rsp_*, mem_*).
// Option: IAS_MEMCTRL_READBACK_EN adds a WR_VERIFY phase per byte; mismatches set rsp_err.
module ias_mem_ctrl
    import ias_mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int MEM_WORDS   = 1000,
    parameter int BYTE_ADDR_W = 15
) (
    input  logic           clk,
    input  logic           rst,
    ias_mem_ctrl_if.slave  bus
);

    localparam logic [2:0] LAST_BYTE = 3'(WORD_BYTES - 1);

    ctrl_state_t            state_q;
    ctrl_state_t            state_d;
    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [WORD_W-1:0]      wdata_q;
    logic [WORD_W-1:0]      asm_q;
    logic [WORD_W-1:0]      rdata_q;
    logic [2:0]             cnt_q;
    logic                   err_q;
    logic [BYTE_ADDR_W-1:0] byte_addr;
    logic [BYTE_W-1:0]      wr_byte;
    logic                   accept;
    logic                   addr_oor;
    logic                   last_byte;

    assign accept    = bus.req_valid && (state_q == IDLE);
    assign addr_oor  = (32'(bus.req_addr) >= MEM_WORDS);
    assign last_byte = (cnt_q == LAST_BYTE);
    assign wr_byte   = get_byte(wdata_q, cnt_q);

    ias_byte_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BYTE_ADDR_W (BYTE_ADDR_W)
    ) u_addr_gen (
        .addr      (addr_q),
        .k         (cnt_q),
        .byte_addr (byte_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (addr_oor)         state_d = DONE;
                    else if (bus.req_we)  state_d = WR_SETUP;
                    else                  state_d = RD_ADDR;
                end
            end
            WR_SETUP:  state_d = WR_STROBE;
            WR_STROBE: state_d = WR_HOLD;
`ifdef IAS_MEMCTRL_READBACK_EN
            WR_HOLD:   state_d = WR_VERIFY;
            WR_VERIFY: state_d = last_byte ? DONE : WR_SETUP;
`else
            WR_HOLD:   state_d = last_byte ? DONE : WR_SETUP;
`endif
            RD_ADDR:   state_d = RD_CAP;
            RD_CAP:    state_d = last_byte ? DONE : RD_ADDR;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Request latch, byte counter, read assembly and error accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        // Cleared so an out-of-range read returns zero.
                        asm_q   <= '0;
                        cnt_q   <= '0;
                        err_q   <= addr_oor;
                    end
                end
`ifdef IAS_MEMCTRL_READBACK_EN
                WR_VERIFY: begin
                    if (bus.mem_rdata != wr_byte) err_q <= 1'b1;
                    if (!last_byte) cnt_q <= cnt_q + 3'd1;
                end
`else
                WR_HOLD: begin
                    if (!last_byte) cnt_q <= cnt_q + 3'd1;
                end
`endif
                RD_CAP: begin
                    asm_q <= put_byte(asm_q, cnt_q, bus.mem_rdata);
                    if (!last_byte) cnt_q <= cnt_q + 3'd1;
                end
                DONE: begin
                    // Writes keep the previous read data on rsp_rdata.
                    if (!we_q) rdata_q <= asm_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_set   = 1'b0;
        case (state_q)
            IDLE: bus.req_ready = 1'b1;
            WR_SETUP, WR_HOLD, WR_VERIFY: begin
                bus.mem_addr  = byte_addr;
                bus.mem_wdata = wr_byte;
            end
            WR_STROBE: begin
                bus.mem_addr  = byte_addr;
                bus.mem_wdata = wr_byte;
                // Gated by rst so an abort during the strobe cycle cannot set a cell.
                bus.mem_set   = !rst;
            end
            RD_ADDR, RD_CAP: bus.mem_addr = byte_addr;
            DONE: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                if (!we_q) bus.rsp_rdata = asm_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ias_mem_ctrl.sv
module tb_ias_mem_ctrl;

`ifdef IAS_MEMCTRL_READBACK_EN
    localparam int LAT_WR = 21;
`else
    localparam int LAT_WR = 16;
`endif
    localparam int LAT_RD  = 11;
    localparam int LAT_OOR = 1;

    typedef struct {
        logic [39:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [14:0] a;
        logic [7:0]  d;
    } stb_t;

    logic clk;
    logic rst;

    ias_mem_ctrl_if #(.ADDR_W(12), .BYTE_ADDR_W(15)) bus ();

    ias_mem_ctrl #(
        .ADDR_W      (12),
        .MEM_WORDS   (1000),
        .BYTE_ADDR_W (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  mem [32768];
    logic        force_en;
    logic [14:0] force_addr;

    rsp_t sb_q[$];
    stb_t stb_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   acc_cnt = 0;
    int   acc_prev = 0;
    int   acc_last = 0;
    int   total = 0;
    int   bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Byte-wide latch array model with combinational read.
    assign bus.mem_rdata = (force_en && bus.mem_addr == force_addr) ? 8'h00 : mem[bus.mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_set === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: acceptance bookkeeping and scoreboard pop on rsp_valid.
    always @(negedge clk) begin
        rsp_t r;
        if (rst) begin
            acc_q.delete();
        end else begin
            if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
                acc_q.push_back(cyc);
                acc_cnt++;
                acc_prev = acc_last;
                acc_last = cyc;
            end
            if (bus.rsp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: rsp_valid with no request pending (cycle %0d)", cyc);
                end else begin
                    r = sb_q.pop_front();
                    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(r.rdata));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(r.err));
                    if (acc_q.size() != 0)
                        chk("rsp_latency", 64'(cyc - acc_q.pop_front()), 64'(r.lat));
                    else
                        chk("rsp_latency", 64'(-1), 64'(r.lat));
                end
            end
        end
    end

    // Strobe monitor: every mem_set cycle must match the next expected byte write.
    always @(negedge clk) begin
        stb_t s;
        if (bus.mem_set !== 1'b0 && bus.mem_set !== 1'bx) begin
            if (stb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: mem_set at addr %0d (cycle %0d)", bus.mem_addr, cyc);
            end else begin
                s = stb_q.pop_front();
                chk("strobe_addr", 64'(bus.mem_addr), 64'(s.a));
                chk("strobe_data", 64'(bus.mem_wdata), 64'(s.d));
            end
        end
    end

    task automatic exp_rsp(input logic [39:0] rd, input logic e, input int lat);
        rsp_t r;
        r.rdata = rd;
        r.err   = e;
        r.lat   = lat;
        sb_q.push_back(r);
    endtask

    task automatic exp_strobes(input int a, input logic [39:0] w);
        stb_t s;
        for (int k = 0; k < 5; k++) begin
            s.a = 15'(5 * a + k);
            s.d = w[8*k +: 8];
            stb_q.push_back(s);
        end
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: req_ready never returned (cycle %0d)", cyc);
        end
    endtask

    task automatic send(input logic we, input logic [11:0] a, input logic [39:0] wd);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int cnt0;
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        rst           = 1'b1;
        force_en      = 1'b0;
        force_addr    = '0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_mem_set", 64'(bus.mem_set), 64'd0);

        // Word 3: bytes 9A,78,56,34,12 at byte addresses 15..19.
        exp_strobes(3, 40'h12_3456_789A);
        exp_rsp(40'h0, 1'b0, LAT_WR);
        send(1'b1, 12'd3, 40'h12_3456_789A);
        drain();
        exp_rsp(40'h12_3456_789A, 1'b0, LAT_RD);
        send(1'b0, 12'd3, 40'h0);
        drain();

        // Top implemented word: byte addresses 4995..4999.
        exp_strobes(999, 40'hA5_C30F_F011);
        exp_rsp(40'h12_3456_789A, 1'b0, LAT_WR);
        send(1'b1, 12'd999, 40'hA5_C30F_F011);
        drain();
        exp_rsp(40'hA5_C30F_F011, 1'b0, LAT_RD);
        send(1'b0, 12'd999, 40'h0);
        drain();

        // Out of range: no array access, zero read data, error flagged.
        exp_rsp(40'h0, 1'b1, LAT_OOR);
        send(1'b0, 12'd1000, 40'h0);
        drain();
        exp_rsp(40'h0, 1'b1, LAT_OOR);
        send(1'b1, 12'd1000, 40'hFF_FFFF_FFFF);
        drain();

        // Reset at T5 of a write: only byte 0 (addr 50) gets strobed.
        begin
            stb_t s;
            s.a = 15'd50;
            s.d = 8'h01;
            stb_q.push_back(s);
        end
        send(1'b1, 12'd10, 40'hDE_ADBE_EF01);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_set", 64'(bus.mem_set), 64'd0);
        chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
        chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        exp_rsp(40'h12_3456_789A, 1'b0, LAT_RD);
        send(1'b0, 12'd3, 40'h0);
        drain();

        // Back-to-back writes with req_valid held high throughout.
        cnt0 = acc_cnt;
        exp_strobes(5, 40'h01_0203_0405);
        exp_strobes(6, 40'hFF_EEDD_CCBB);
        exp_rsp(40'h12_3456_789A, 1'b0, LAT_WR);
        exp_rsp(40'h12_3456_789A, 1'b0, LAT_WR);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 12'd5;
        bus.req_wdata = 40'h01_0203_0405;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_addr  = 12'd6;
        bus.req_wdata = 40'hFF_EEDD_CCBB;
        wait_ready();
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        drain();
        chk("b2b_accepts", 64'(acc_cnt - cnt0), 64'd2);
        chk("b2b_spacing", 64'(acc_last - acc_prev), 64'(LAT_WR + 1));
        exp_rsp(40'hFF_EEDD_CCBB, 1'b0, LAT_RD);
        send(1'b0, 12'd6, 40'h0);
        drain();

`ifdef IAS_MEMCTRL_READBACK_EN
        // Byte 2 of word 7 (addr 37) reads back as 00: all strobes still happen, error set.
        force_addr = 15'd37;
        force_en   = 1'b1;
        exp_strobes(7, 40'h11_2233_4455);
        exp_rsp(40'hFF_EEDD_CCBB, 1'b1, LAT_WR);
        send(1'b1, 12'd7, 40'h11_2233_4455);
        drain();
        force_en = 1'b0;
        exp_rsp(40'h11_2233_4455, 1'b0, LAT_RD);
        send(1'b0, 12'd7, 40'h0);
        drain();
`endif

        repeat (3) @(negedge clk);
        chk("strobes_left", 64'(stb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
